rgb_stream_tx: RTL
==================

# rgb_stream_tx

Video-timing transmitter that reads pixel batches from the block buffer's read port and drives an RGB parallel stream (DE/HS/VS plus per-channel 8-bit color). It mirrors the batching and packing of the input path: each buffer word carries BATCH_SIZE pixels for every channel. It is used for HDMI pass-through output and as a loopback stimulus source for the input logic. Line-done and frame-start pulses let the buffer controller swap blocks.

## Interface
- BATCH_SIZE, 4, pixels per buffer word.
- CHANNEL_COUNT, 3, color channels.
- H_ACTIVE, 1920, active pixels per line; must be a multiple of BATCH_SIZE.
- H_FRONT, 88; H_SYNC, 44; H_BACK, 148, horizontal blanking in clocks.
- V_ACTIVE, 1080; V_FRONT, 4; V_SYNC, 5; V_BACK, 36, vertical blanking in lines.
- ADDRESS_BITS, $clog2(H_ACTIVE/BATCH_SIZE), read-address width.

Ports:
- I_rgb_clk  in  1  pixel clock.
- I_rst_n  in  1  asynchronous, active-low reset.
- O_rd_address  out  ADDRESS_BITS  buffer read address (word index within the line).
- O_rd_enable  out  1  read strobe, one cycle per word.
- I_rd_data  in  8*BATCH_SIZE*CHANNEL_COUNT  read data, valid exactly 1 cycle after O_rd_enable.
- O_rgb_de  out  1  data enable.
- O_rgb_hs  out  1  horizontal sync, active high.
- O_rgb_vs  out  1  vertical sync, active high.
- O_rgb_color  out  [CHANNEL_COUNT-1:0][7:0]  pixel color.
- O_line_done  out  1  one-cycle pulse after the last pixel of an active line.
- O_frame_start  out  1  one-cycle pulse coincident with pixel (0,0).
- I_pattern_en  in  1  present only when RGB_TX_PATTERN_EN is defined.

## Operation
- Free-running counters: h_cnt runs 0..H_TOTAL-1 and v_cnt runs 0..V_TOTAL-1; v_cnt increments when h_cnt wraps.
- Region order for both axes is active, front porch, sync, back porch. Active is h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
- HS is high for H_ACTIVE+H_FRONT ≤ h_cnt < H_ACTIVE+H_FRONT+H_SYNC, on every line.
- VS is high for the whole of lines V_ACTIVE+V_FRONT ≤ v_cnt < V_ACTIVE+V_FRONT+V_SYNC.
- Fetch: in the active region, when h_cnt mod BATCH_SIZE == 0, assert O_rd_enable with O_rd_address = h_cnt/BATCH_SIZE. There are no reads in blanking, and the address returns to 0 at each line.
- Word packing:
  - Channel c occupies bits [8*BATCH_SIZE*(c+1)-1 : 8*BATCH_SIZE*c].
  - Pixel k of the batch is byte k inside that field, with pixel 0 in the LSB byte.
- Unpack: the returned word loads a holding register. Byte 0 drives the output immediately; each following clock shifts the next byte out, for BATCH_SIZE pixels total.
- O_rgb_color is 0 whenever O_rgb_de is low.
- O_line_done pulses on the first cycle O_rgb_de is low after an active line. It fires V_ACTIVE times per frame.
- Reset (async):
  - Counters return to h=0, v=0.
  - All outputs are 0 and the holding register is cleared.
  - Reset mid-line aborts the line with no O_line_done.
  - On release, the first clock edge issues the read for word 0.

## Timing
- All outputs are registered.
- DE, HS, VS, color, O_line_done and O_frame_start are delayed 2 clocks from the counter state that generates them:
  - cycle t: counter state, read issue;
  - cycle t+1: data returns;
  - cycle t+2: pixel visible.
- O_rd_enable and O_rd_address are driven combinationally from counter state registered at t, and are visible in cycle t.
- First O_rgb_de after reset release is in cycle 2, where cycle 0 is the first edge after release.
- O_rgb_de stays high for exactly H_ACTIVE consecutive cycles per active line.
- The buffer must have exactly 1-cycle read latency. The block has no backpressure and never stalls.

## Configuration
- RGB_TX_PATTERN_EN defined:
  - The I_pattern_en port exists.
  - When I_pattern_en is high, the block outputs 8 vertical color bars, each H_ACTIVE/8 wide.
  - Bar i drives channel c to 255 if bit c of i is set, else 0 (channels 0..2; higher channels 0).
  - O_rd_enable is held 0 while I_pattern_en is high.
  - I_pattern_en is sampled at frame start only.
  - Timing and pulses are unchanged.
- RGB_TX_PATTERN_EN undefined: no port and no pattern logic; the block always outputs buffer data.

## Test plan
Benches use H_ACTIVE=8, H_FRONT=2, H_SYNC=2, H_BACK=2, V_ACTIVE=2, V_FRONT=1, V_SYNC=1, V_BACK=1, giving H_TOTAL=14 and V_TOTAL=5.
- Fetch and unpack:
  - Stimulus: release reset; model returns word 0 = {0x2B2A2928, 0x1B1A1918, 0x0B0A0908} and word 1 = {0x2F2E2D2C, 0x1F1E1D1C, 0x0F0E0D0C}, i.e. channel c, pixel x = 0x08+0x10*c+x.
  - Response: reads at cycles 0 and 4 with addresses 0 and 1; DE high in cycles 2..9; channel 0 outputs 0x08..0x0F in order; color is 0 outside DE.
- Sync placement: run one frame → HS high for 2 cycles starting 10 cycles after DE rises on every line; VS high for exactly the 14-cycle line 3, aligned with the delayed counter; frame period is 70 cycles.
- Pulses: run a full frame → O_frame_start fires once, in the same cycle as the first DE; O_line_done fires twice, each in the cycle DE falls.
- Reset mid-line: assert I_rst_n low in cycle 5 → all outputs 0 immediately, no O_line_done; after release, reads restart at address 0.
- Back-to-back frames: run 3 frames → addresses 0,1 on each active line; no reads during lines 2..4.
- Pattern (macro defined): set I_pattern_en=1 before frame start → pixel x shows channels {bit0,bit1,bit2} of x as 255/0 (bar width 1); O_rd_enable stays 0 for the whole frame.

Source files
------------

// File: rtl/rgb_stream_tx.sv
// RGB parallel video transmitter: free-running video timing, one buffer read per pixel batch, two-stage
// pipeline to the pins. Defining RGB_TX_PATTERN_EN adds I_pattern_en and an 8-bar color test pattern.
module rgb_stream_tx #(
  parameter int BATCH_SIZE    = 4,
  parameter int CHANNEL_COUNT = 3,
  parameter int H_ACTIVE      = 1920,
  parameter int H_FRONT       = 88,
  parameter int H_SYNC        = 44,
  parameter int H_BACK        = 148,
  parameter int V_ACTIVE      = 1080,
  parameter int V_FRONT       = 4,
  parameter int V_SYNC        = 5,
  parameter int V_BACK        = 36,
  parameter int ADDRESS_BITS  = $clog2(H_ACTIVE / BATCH_SIZE)
) (
  input  logic                                  I_rgb_clk,
  input  logic                                  I_rst_n,
  output logic [ADDRESS_BITS-1:0]               O_rd_address,
  output logic                                  O_rd_enable,
  input  logic [8*BATCH_SIZE*CHANNEL_COUNT-1:0] I_rd_data,
  output logic                                  O_rgb_de,
  output logic                                  O_rgb_hs,
  output logic                                  O_rgb_vs,
  output logic [CHANNEL_COUNT-1:0][7:0]         O_rgb_color,
  output logic                                  O_line_done,
  output logic                                  O_frame_start
`ifdef RGB_TX_PATTERN_EN
  ,
  input  logic                                  I_pattern_en
`endif
);

  localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW       = $clog2(H_TOTAL);
  localparam int VW       = $clog2(V_TOTAL);
  localparam int WORDS    = H_ACTIVE / BATCH_SIZE;
  localparam int PW       = (BATCH_SIZE > 1) ? $clog2(BATCH_SIZE) : 1;
  localparam int HS_START = H_ACTIVE + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC;

  // Buffer word viewed as [channel][pixel][bit]; pixel 0 of channel 0 sits in the LSB byte.
  typedef logic [CHANNEL_COUNT-1:0][BATCH_SIZE-1:0][7:0] word_t;

  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
    logic frame_start;
    logic line_done;
  } ctl_t;

  logic [HW-1:0]           h_cnt_q, h_cnt_d;
  logic [VW-1:0]           v_cnt_q, v_cnt_d;
  logic [PW-1:0]           phase_q, phase_d;
  logic [ADDRESS_BITS-1:0] word_q, word_d;
  int                      h_pos, v_pos;
  logic                    h_active, v_active, rd_issue;

  ctl_t                    ctl_s1_d, ctl_s1_q, ctl_out_q;
  logic                    data_valid_q;
  word_t                   rd_word, src, hold_q, hold_d;
  logic [CHANNEL_COUNT-1:0][7:0] color_d, color_q;

  assign h_pos    = int'(h_cnt_q);
  assign v_pos    = int'(v_cnt_q);
  assign h_active = h_pos < H_ACTIVE;
  assign v_active = v_pos < V_ACTIVE;
  assign rd_word  = I_rd_data;

`ifdef RGB_TX_PATTERN_EN
  logic       pat_q, pat_eff, pat_s1_q;
  logic [2:0] bar, bar_s1_q;

  // The pattern choice is latched when the counters sit on pixel (0,0) and held for the whole frame.
  assign pat_eff = (h_cnt_q == '0 && v_cnt_q == '0) ? I_pattern_en : pat_q;
  assign bar     = 3'((h_pos * 8) / H_ACTIVE);
  assign rd_issue = I_rst_n && h_active && v_active && (phase_q == '0) && !pat_eff;
`else
  // Gated by reset so the strobe is low while the counters are parked at (0,0).
  assign rd_issue = I_rst_n && h_active && v_active && (phase_q == '0);
`endif

  assign O_rd_enable  = rd_issue;
  assign O_rd_address = word_q;

  // NOTE: every signal written in an always_comb gets a default first, so no latch is inferred.
  always_comb begin
    h_cnt_d = h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    phase_d = phase_q;
    word_d  = word_q;
    if (h_cnt_q == HW'(H_TOTAL - 1)) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == VW'(V_TOTAL - 1)) ? '0 : v_cnt_q + 1'b1;
    end
    if (h_active) begin
      if (phase_q == PW'(BATCH_SIZE - 1)) begin
        phase_d = '0;
        word_d  = (word_q == ADDRESS_BITS'(WORDS - 1)) ? '0 : word_q + 1'b1;
      end else begin
        phase_d = phase_q + 1'b1;
      end
    end
  end

  always_comb begin
    ctl_s1_d             = '0;
    ctl_s1_d.de          = h_active && v_active;
    ctl_s1_d.hs          = (h_pos >= HS_START) && (h_pos < HS_END);
    ctl_s1_d.vs          = (v_pos >= VS_START) && (v_pos < VS_END);
    ctl_s1_d.frame_start = (h_cnt_q == '0) && (v_cnt_q == '0);
    ctl_s1_d.line_done   = (h_pos == H_ACTIVE) && v_active;
  end

  // A fresh word supplies pixel 0 directly; the rest of the batch shifts out of the holding register.
  always_comb begin
    color_d = '0;
    hold_d  = hold_q;
    src     = data_valid_q ? rd_word : hold_q;
    if (ctl_s1_q.de) begin
      for (int c = 0; c < CHANNEL_COUNT; c++) begin
        color_d[c] = src[c][0];
        for (int k = 0; k < BATCH_SIZE - 1; k++) begin
          hold_d[c][k] = src[c][k+1];
        end
        hold_d[c][BATCH_SIZE-1] = '0;
      end
`ifdef RGB_TX_PATTERN_EN
      if (pat_s1_q) begin
        for (int c = 0; c < CHANNEL_COUNT; c++) begin
          color_d[c] = ((c < 3) && bar_s1_q[2'(c)]) ? 8'hFF : 8'h00;
        end
      end
`endif
    end
  end

  // NOTE: non-blocking assignments so every register samples the values from before the edge.
  always_ff @(posedge I_rgb_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      phase_q <= '0;
      word_q  <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      phase_q <= phase_d;
      word_q  <= word_d;
    end
  end

  always_ff @(posedge I_rgb_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      ctl_s1_q     <= '0;
      ctl_out_q    <= '0;
      data_valid_q <= 1'b0;
      color_q      <= '0;
      // NOTE: the datapath holding register is reset too, so an aborted line cannot leak stale pixels.
      hold_q       <= '0;
    end else begin
      ctl_s1_q     <= ctl_s1_d;
      ctl_out_q    <= ctl_s1_q;
      data_valid_q <= rd_issue;
      color_q      <= color_d;
      hold_q       <= hold_d;
    end
  end

`ifdef RGB_TX_PATTERN_EN
  always_ff @(posedge I_rgb_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      pat_q    <= 1'b0;
      pat_s1_q <= 1'b0;
      bar_s1_q <= '0;
    end else begin
      pat_q    <= pat_eff;
      pat_s1_q <= pat_eff;
      bar_s1_q <= bar;
    end
  end
`endif

  assign O_rgb_de      = ctl_out_q.de;
  assign O_rgb_hs      = ctl_out_q.hs;
  assign O_rgb_vs      = ctl_out_q.vs;
  assign O_line_done   = ctl_out_q.line_done;
  assign O_frame_start = ctl_out_q.frame_start;
  assign O_rgb_color   = color_q;

endmodule
